btn_debounce: RTL and testbench



---
 rtl/myPkg.sv | 19 +
 rtl/btn_sync.sv | 28 ++
 rtl/btn_debounce.sv | 128 ++++++++++++
 tb/tb_btn_debounce.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/myPkg.sv
// Shared types and defaults for the push-button front end.
// The state enum and timing defaults are shared by any pin-input block built on it.
package myPkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } btn_state_e;

    localparam int unsigned BTN_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned BTN_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned BTN_REPEAT_RATE     = 5_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Generic 2-flop synchroniser for an asynchronous pin; flops reset to RESET_VAL.
// Latency 2 cycles; no backpressure (free-running sampler).
module btn_sync #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Active-low button front end: sync, debounce, press/auto-repeat/release pulses.
// Press appears DEBOUNCE_CYCLES+2 cycles after the pin settles; outputs registered, no backpressure.
module btn_debounce
    import myPkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = BTN_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = BTN_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic press_o,
    output logic rep_o,
    output logic release_o,
    output logic step_o
);

    localparam int unsigned RPT_MAX = max_u(REPEAT_DELAY, REPEAT_RATE);
    localparam int          DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int          RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [RPT_W-1:0] RPT_SAT    = RPT_W'(RPT_MAX);

    logic             btn_n_sync;
    logic             stable_q, stable_d;   // pin polarity: 1 = released
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             accept;
    btn_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             press_q, press_d;
    logic             rep_q, rep_d;
    logic             release_q, release_d;
    logic             step_q;

    btn_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_n_i),
        .q_o   (btn_n_sync)
    );

    // The accepting edge both flips the stable level and drives the FSM, so press lands one cycle earlier.
    always_comb begin
        accept   = 1'b0;
        stable_d = stable_q;
        db_cnt_d = '0;
        if (btn_n_sync != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                accept   = 1'b1;
                stable_d = btn_n_sync;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        press_d   = 1'b0;
        rep_d     = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = HOLD_DELAY;
                    press_d   = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
            HOLD_DELAY, HOLD_REPEAT: begin
                // A release accepted on an expiring count suppresses that repeat.
                if (accept) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == ((state_q == HOLD_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    state_d   = HOLD_REPEAT;
                    rep_d     = 1'b1;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q != RPT_SAT) begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= 1'b1;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            press_q   <= 1'b0;
            rep_q     <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            press_q   <= press_d;
            rep_q     <= rep_d;
            release_q <= release_d;
            step_q    <= press_d | rep_d;
        end
    end

    assign pressed_o = (state_q != IDLE);
    assign press_o   = press_q;
    assign rep_o     = rep_q;
    assign release_o = release_q;
    assign step_o    = step_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a timing-level reference model checked every cycle.
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_n;
    logic pressed_o, press_o, rep_o, release_o, step_o;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n_i   (btn_n),
        .pressed_o (pressed_o),
        .press_o   (press_o),
        .rep_o     (rep_o),
        .release_o (release_o),
        .step_o    (step_o)
    );

    always #5 clk = ~clk;

    // Reference model: the pin is seen two edges late; a level is accepted after DB consecutive
    // differing edges; while held, a repeat fires RD cycles after press, then every RR cycles.
    bit h1 = 1'b1, h2 = 1'b1;
    bit m_rel = 1'b1;
    int m_run = 0;
    bit m_held = 1'b0;
    int m_age = 0;
    int m_gap = RD;
    bit e_press = 1'b0, e_rep = 1'b0, e_rel = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit lvl;
        if (!rst_n) begin
            h1 = 1'b1; h2 = 1'b1; m_rel = 1'b1; m_run = 0;
            m_held = 1'b0; m_age = 0; m_gap = RD;
            e_press = 1'b0; e_rep = 1'b0; e_rel = 1'b0;
        end else begin
            lvl = h2;
            h2 = h1;
            h1 = btn_n;
            e_press = 1'b0; e_rep = 1'b0; e_rel = 1'b0;
            m_run = (lvl != m_rel) ? m_run + 1 : 0;
            if (m_run == DB) begin
                m_rel = lvl;
                m_run = 0;
                if (!lvl) begin
                    m_held = 1'b1; e_press = 1'b1; m_age = 0; m_gap = RD;
                end else begin
                    m_held = 1'b0; e_rel = 1'b1;
                end
            end else if (m_held) begin
                m_age++;
                if (m_age == m_gap) begin
                    e_rep = 1'b1; m_age = 0; m_gap = RR;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int press_log[$];
    int rep_log[$];
    int rel_log[$];
    int step_cnt = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check("model_pressed", pressed_o, m_held);
        check("model_press", press_o, e_press);
        check("model_rep", rep_o, e_rep);
        check("model_release", release_o, e_rel);
        check("model_step", step_o, e_press | e_rep);
        if (press_o) press_log.push_back(cyc);
        if (rep_o) rep_log.push_back(cyc);
        if (release_o) rel_log.push_back(cyc);
        if (step_o) step_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        press_log.delete();
        rep_log.delete();
        rel_log.delete();
        step_cnt = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pressed"}, pressed_o, 1'b0);
        check({tag, "_press"}, press_o, 1'b0);
        check({tag, "_rep"}, rep_o, 1'b0);
        check({tag, "_release"}, release_o, 1'b0);
        check({tag, "_step"}, step_o, 1'b0);
    endtask

    initial begin
        int c0, p;
        rst_n = 1'b0;
        btn_n = 1'b1;
        #1;
        check_outputs_zero("reset");
        run(3);
        rst_n = 1'b1;
        run(5);

        // Clean press, 30 cycles of hold with auto-repeat, then release.
        clear_logs();
        c0 = cyc;
        btn_n = 1'b0;
        run(6);
        p = cyc;
        check_int("t1_press_cyc", p, c0 + 6);
        check("t1_press_now", press_o, 1'b1);
        check("t1_step_now", step_o, 1'b1);
        check("t1_pressed_now", pressed_o, 1'b1);
        run(30);
        check_int("t1_press_cnt", press_log.size(), 1);
        check_int("t1_rep_cnt", rep_log.size(), 7);
        if (rep_log.size() == 7) begin
            check_int("t1_rep_first", rep_log[0], p + 10);
            check_int("t1_rep_second", rep_log[1], p + 13);
            check_int("t1_rep_last", rep_log[6], p + 28);
        end
        check_int("t1_step_cnt", step_cnt, 8);
        clear_logs();
        c0 = cyc;
        btn_n = 1'b1;
        run(6);
        check_int("t1_rel_cnt", rel_log.size(), 1);
        if (rel_log.size() > 0) check_int("t1_rel_cyc", rel_log[0], c0 + 6);
        run(10);
        check("t1_pressed_after", pressed_o, 1'b0);

        // Glitch one cycle short of the debounce window.
        clear_logs();
        btn_n = 1'b0;
        run(3);
        btn_n = 1'b1;
        run(10);
        check_int("glitch_press_cnt", press_log.size(), 0);
        check_int("glitch_rel_cnt", rel_log.size(), 0);

        // Bounce: toggle every 2 cycles for 20 cycles.
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(2);
        end
        btn_n = 1'b1;
        run(10);
        check_int("bounce_press_cnt", press_log.size(), 0);
        check_int("bounce_rep_cnt", rep_log.size(), 0);
        check_int("bounce_rel_cnt", rel_log.size(), 0);
        check("bounce_pressed", pressed_o, 1'b0);

        // Release during the repeat delay.
        clear_logs();
        btn_n = 1'b0;
        run(6);
        p = cyc;
        check_int("t3_press_cnt", press_log.size(), 1);
        btn_n = 1'b1;
        run(10);
        check_int("t3_rel_cnt", rel_log.size(), 1);
        if (rel_log.size() > 0) check_int("t3_rel_cyc", rel_log[0], p + 6);
        check_int("t3_rep_cnt", rep_log.size(), 0);
        check("t3_pressed", pressed_o, 1'b0);

        // Release accepted on the same cycle the second repeat would fire.
        clear_logs();
        btn_n = 1'b0;
        run(6);
        p = cyc;
        run(7);
        btn_n = 1'b1;
        run(12);
        check_int("t4_rep_cnt", rep_log.size(), 1);
        if (rep_log.size() > 0) check_int("t4_rep_cyc", rep_log[0], p + 10);
        check_int("t4_rel_cnt", rel_log.size(), 1);
        if (rel_log.size() > 0) check_int("t4_rel_cyc", rel_log[0], p + 13);

        // Reset while in auto-repeat with the button still held.
        clear_logs();
        btn_n = 1'b0;
        run(6);
        run(12);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        run(2);
        rst_n = 1'b1;
        clear_logs();
        c0 = cyc;
        run(8);
        check_int("t5_press_cnt", press_log.size(), 1);
        if (press_log.size() > 0) check_int("t5_press_cyc", press_log[0], c0 + 6);
        check("t5_pressed", pressed_o, 1'b1);
        btn_n = 1'b1;
        run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
